char_grid_writer: RTL and testbench

CHAR_GRID_WRITER -- requirements
Module: char_grid_writer

---
 rtl/char_grid_writer.sv | 159 +++++++++++++++
 tb/tb_char_grid_writer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/char_grid_writer.sv
// Character-to-grid writer: maps character codes to glyph indices and writes them into a
// COLS x ROWS frame buffer at a cursor, handling backspace, newline and a full-screen clear.
module char_grid_writer #(
   parameter int COLS        = 20,
   parameter int ROWS        = 7,
   parameter int WRAP_MODE   = 0,
   parameter int BLANK_GLYPH = 128,
   parameter int UNK_GLYPH   = 128,
   localparam int N  = COLS * ROWS,
   localparam int AW = $clog2(N),
   localparam int CW = $clog2(COLS),
   localparam int RW = $clog2(ROWS)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   input  logic [7:0]    in_char,
   output logic          in_ready,
   output logic          wr_en,
   output logic [AW-1:0] wr_addr,
   output logic [7:0]    wr_glyph,
   output logic [CW-1:0] cur_col,
   output logic [RW-1:0] cur_row,
   output logic          screen_wrap,
   output logic          full,
   output logic          busy
);
   localparam logic [AW-1:0] LAST_ADDR = AW'(N - 1);
   localparam logic [CW-1:0] LAST_COL  = CW'(COLS - 1);
   localparam logic [RW-1:0] LAST_ROW  = RW'(ROWS - 1);
   localparam logic [7:0]    BLANK     = 8'(BLANK_GLYPH);
   localparam logic [7:0]    UNK       = 8'(UNK_GLYPH);

   typedef enum logic {IDLE, CLEAR} state_t;
   state_t state, state_nxt;

   logic          wr_en_nxt, wrap_nxt, full_nxt;
   logic [AW-1:0] addr_nxt, cur_addr;
   logic [7:0]    glyph_nxt;
   logic [CW-1:0] col_nxt;
   logic [RW-1:0] row_nxt;
   logic          hs, is_ctrl;

   function automatic logic [7:0] glyph_of(input logic [7:0] c);
      if (c >= 8'h30 && c <= 8'h39) return c - 8'd48;
      if (c >= 8'h41 && c <= 8'h5A) return c - 8'd55;
      if (c >= 8'h61 && c <= 8'h7A) return c - 8'd61;
      if (c >= 8'h80 && c <= 8'hC3) return c - 8'd66;
      return UNK;
   endfunction

   assign in_ready = rst_n && (state == IDLE);
   assign busy     = rst_n && (state == CLEAR);
   assign hs       = in_valid && in_ready;
   assign is_ctrl  = (in_char < 8'h20) || (in_char == 8'h7F);
   assign cur_addr = AW'(int'(cur_row) * COLS + int'(cur_col));

   always_comb begin
      state_nxt = state;
      wr_en_nxt = 1'b0;
      wrap_nxt  = 1'b0;
      addr_nxt  = wr_addr;
      glyph_nxt = wr_glyph;
      col_nxt   = cur_col;
      row_nxt   = cur_row;
      full_nxt  = full;
      case (state)
         IDLE: if (hs) begin
            if (in_char == 8'hFF) begin
               state_nxt = CLEAR;
               wr_en_nxt = 1'b1;
               addr_nxt  = '0;
               glyph_nxt = BLANK;
            end else if (in_char == 8'h08) begin
               // A full grid keeps its cursor on the last cell; backspace only blanks it.
               if (full) begin
                  wr_en_nxt = 1'b1;
                  addr_nxt  = LAST_ADDR;
                  glyph_nxt = BLANK;
                  full_nxt  = 1'b0;
               end else if (cur_addr != '0) begin
                  wr_en_nxt = 1'b1;
                  addr_nxt  = cur_addr - AW'(1);
                  glyph_nxt = BLANK;
                  if (cur_col == '0) begin
                     col_nxt = LAST_COL;
                     row_nxt = cur_row - RW'(1);
                  end else begin
                     col_nxt = cur_col - CW'(1);
                  end
               end
            end else if (in_char == 8'h0A) begin
               if (cur_row != LAST_ROW) begin
                  col_nxt = '0;
                  row_nxt = cur_row + RW'(1);
               end else if (WRAP_MODE == 0) begin
                  col_nxt  = '0;
                  row_nxt  = '0;
                  wrap_nxt = 1'b1;
               end
            end else if (!is_ctrl && !full) begin
               wr_en_nxt = 1'b1;
               addr_nxt  = cur_addr;
               glyph_nxt = glyph_of(in_char);
               if (cur_addr == LAST_ADDR) begin
                  if (WRAP_MODE == 0) begin
                     col_nxt  = '0;
                     row_nxt  = '0;
                     wrap_nxt = 1'b1;
                  end else begin
                     full_nxt = 1'b1;
                  end
               end else if (cur_col == LAST_COL) begin
                  col_nxt = '0;
                  row_nxt = cur_row + RW'(1);
               end else begin
                  col_nxt = cur_col + CW'(1);
               end
            end
         end
         CLEAR: begin
            // wr_addr holds the previously swept cell, so it doubles as the sweep counter.
            if (wr_addr == LAST_ADDR) begin
               state_nxt = IDLE;
               col_nxt   = '0;
               row_nxt   = '0;
               full_nxt  = 1'b0;
            end else begin
               wr_en_nxt = 1'b1;
               addr_nxt  = wr_addr + AW'(1);
               glyph_nxt = BLANK;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         wr_en       <= 1'b0;
         wr_addr     <= '0;
         wr_glyph    <= '0;
         cur_col     <= '0;
         cur_row     <= '0;
         screen_wrap <= 1'b0;
         full        <= 1'b0;
      end else begin
         state       <= state_nxt;
         wr_en       <= wr_en_nxt;
         wr_addr     <= addr_nxt;
         wr_glyph    <= glyph_nxt;
         cur_col     <= col_nxt;
         cur_row     <= row_nxt;
         screen_wrap <= wrap_nxt;
         full        <= full_nxt;
      end
   end
endmodule

// File: tb/tb_char_grid_writer.sv
// Bench for char_grid_writer: a wrap-mode and a stop-mode instance share one stimulus
// stream and are each compared against a linear-cursor reference model every cycle.
module tb_char_grid_writer;
   localparam int COLS = 20, ROWS = 7, N = COLS * ROWS;
   localparam int AW = $clog2(N), CW = $clog2(COLS), RW = $clog2(ROWS);
   localparam int VW = AW + RW + CW + 13;
   localparam logic [7:0] BLANK = 8'd128;

   logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0;
   logic [7:0] in_char = 8'h00;
   logic in_ready[2], wr_en[2], screen_wrap[2], full[2], busy[2];
   logic [AW-1:0] wr_addr[2];
   logic [7:0] wr_glyph[2];
   logic [CW-1:0] cur_col[2];
   logic [RW-1:0] cur_row[2];

   int total = 0, bad = 0;

   // reference model: cursor as a linear cell index, index 0 = wrap mode, 1 = stop mode
   int mpos[2], e_addr[2], clr_idx;
   bit mfull[2], e_we[2], e_sw[2], mbusy, mrdy;
   logic [7:0] e_gly[2];

   always #5 clk = ~clk;

   char_grid_writer #(.COLS(COLS), .ROWS(ROWS), .WRAP_MODE(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_char(in_char), .in_ready(in_ready[0]),
      .wr_en(wr_en[0]), .wr_addr(wr_addr[0]), .wr_glyph(wr_glyph[0]), .cur_col(cur_col[0]),
      .cur_row(cur_row[0]), .screen_wrap(screen_wrap[0]), .full(full[0]), .busy(busy[0]));
   char_grid_writer #(.COLS(COLS), .ROWS(ROWS), .WRAP_MODE(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_char(in_char), .in_ready(in_ready[1]),
      .wr_en(wr_en[1]), .wr_addr(wr_addr[1]), .wr_glyph(wr_glyph[1]), .cur_col(cur_col[1]),
      .cur_row(cur_row[1]), .screen_wrap(screen_wrap[1]), .full(full[1]), .busy(busy[1]));

   function automatic logic [7:0] ref_glyph(input int c);
      if (c >= "0" && c <= "9") return 8'(c - "0");
      if (c >= "A" && c <= "Z") return 8'(c - "A" + 10);
      if (c >= "a" && c <= "z") return 8'(c - "a" + 36);
      if (c >= 128 && c <= 195) return 8'(c - 128 + 62);
      return 8'd128;
   endfunction

   task automatic model_apply(input int m, input int c);
      int r;
      if (c == 8'h08) begin
         if (mfull[m]) begin
            e_we[m] = 1; e_addr[m] = N - 1; e_gly[m] = BLANK; mfull[m] = 0;
         end else if (mpos[m] > 0) begin
            mpos[m]--; e_we[m] = 1; e_addr[m] = mpos[m]; e_gly[m] = BLANK;
         end
      end else if (c == 8'h0A) begin
         r = mpos[m] / COLS;
         if (r < ROWS - 1) mpos[m] = (r + 1) * COLS;
         else if (m == 0) begin mpos[m] = 0; e_sw[m] = 1; end
      end else if (c >= 8'h20 && c != 8'h7F && !mfull[m]) begin
         e_we[m] = 1; e_addr[m] = mpos[m]; e_gly[m] = ref_glyph(c);
         if (mpos[m] == N - 1) begin
            if (m == 0) begin mpos[m] = 0; e_sw[m] = 1; end
            else mfull[m] = 1;
         end else mpos[m]++;
      end
   endtask

   function automatic logic [VW-1:0] obs_vec(input int m);
      return {wr_en[m], wr_en[m] ? wr_addr[m] : AW'(0), wr_en[m] ? wr_glyph[m] : 8'd0,
              screen_wrap[m], cur_row[m], cur_col[m], full[m], busy[m], in_ready[m]};
   endfunction

   function automatic logic [VW-1:0] exp_vec(input int m);
      return {e_we[m], e_we[m] ? AW'(e_addr[m]) : AW'(0), e_we[m] ? e_gly[m] : 8'd0,
              e_sw[m], RW'(mpos[m] / COLS), CW'(mpos[m] % COLS), mfull[m], mbusy, mrdy};
   endfunction

   // one clock: drive at negedge, let the edge pass, advance the model, return at negedge
   task automatic cyc(input bit v, input logic [7:0] c);
      bit hs;
      in_valid = v; in_char = c;
      hs = v && mrdy;
      @(posedge clk); @(negedge clk);
      for (int m = 0; m < 2; m++) begin e_we[m] = 0; e_sw[m] = 0; end
      if (mbusy) begin
         if (clr_idx < N) begin
            for (int m = 0; m < 2; m++) begin e_we[m] = 1; e_addr[m] = clr_idx; e_gly[m] = BLANK; end
            clr_idx++;
         end else begin
            mbusy = 0; mrdy = 1;
            for (int m = 0; m < 2; m++) begin mpos[m] = 0; mfull[m] = 0; end
         end
      end else if (hs) begin
         if (c == 8'hFF) begin
            mbusy = 1; mrdy = 0; clr_idx = 1;
            for (int m = 0; m < 2; m++) begin e_we[m] = 1; e_addr[m] = 0; e_gly[m] = BLANK; end
         end else for (int m = 0; m < 2; m++) model_apply(m, c);
      end
   endtask

   task automatic do_reset;
      rst_n = 0; in_valid = 0; in_char = 0;
      @(posedge clk); @(negedge clk);
      for (int m = 0; m < 2; m++) begin
         mpos[m] = 0; mfull[m] = 0; e_we[m] = 0; e_sw[m] = 0; e_addr[m] = 0; e_gly[m] = 0;
      end
      mbusy = 0; mrdy = 0; clr_idx = 0;
      rst_n = 1; mrdy = 1; #1;
   endtask

   function automatic logic [7:0] rnd_printable();
      logic [7:0] c;
      c = 8'($urandom_range(8'h20, 8'hFE));
      if (c == 8'h7F) c = 8'h41;
      return c;
   endfunction

   task automatic test_reset;
      rst_n = 0; in_valid = 1; in_char = 8'h41;
      @(posedge clk); @(negedge clk); @(posedge clk); @(negedge clk);
      for (int m = 0; m < 2; m++) begin
         mpos[m] = 0; mfull[m] = 0; e_we[m] = 0; e_sw[m] = 0;
      end
      mbusy = 0; mrdy = 0; clr_idx = 0;
      for (int m = 0; m < 2; m++) begin
         total++;
         if (obs_vec(m) !== exp_vec(m) || wr_addr[m] !== '0 || wr_glyph[m] !== 8'd0) begin
            bad++;
            $display("FAIL reset m%0d: got %h addr %h glyph %h, want %h addr 0 glyph 0",
                     m, obs_vec(m), wr_addr[m], wr_glyph[m], exp_vec(m));
         end
      end
      in_valid = 0; rst_n = 1; mrdy = 1; #1;
      for (int m = 0; m < 2; m++) begin
         total++;
         if (in_ready[m] !== 1'b1) begin bad++; $display("FAIL reset_release m%0d: in_ready %b want 1", m, in_ready[m]); end
      end
   endtask

   task automatic test_basic;
      cyc(1, 8'h41);
      for (int m = 0; m < 2; m++) begin
         total++;
         if (obs_vec(m) !== exp_vec(m) || wr_glyph[m] !== 8'd10 || cur_col[m] !== CW'(1)) begin
            bad++; $display("FAIL basic_A m%0d: got %h want %h", m, obs_vec(m), exp_vec(m));
         end
      end
      cyc(0, 8'h00);
      for (int m = 0; m < 2; m++) begin
         total++;
         if (obs_vec(m) !== exp_vec(m)) begin bad++; $display("FAIL basic_idle m%0d: got %h want %h", m, obs_vec(m), exp_vec(m)); end
      end
   endtask

   task automatic test_fill;
      do_reset;
      for (int i = 0; i < N; i++) begin
         cyc(1, 8'h30);
         for (int m = 0; m < 2; m++) begin
            total++;
            if (obs_vec(m) !== exp_vec(m)) begin bad++; $display("FAIL fill[%0d] m%0d: got %h want %h", i, m, obs_vec(m), exp_vec(m)); end
         end
      end
      cyc(0, 8'h00);
      for (int m = 0; m < 2; m++) begin
         total++;
         if (obs_vec(m) !== exp_vec(m)) begin bad++; $display("FAIL fill_after m%0d: got %h want %h", m, obs_vec(m), exp_vec(m)); end
      end
   endtask

   task automatic test_clear;
      cyc(1, 8'hFF);
      // keep offering a character during the sweep; it must not be taken
      for (int i = 0; i <= N; i++) begin
         for (int m = 0; m < 2; m++) begin
            total++;
            if (obs_vec(m) !== exp_vec(m)) begin bad++; $display("FAIL clear[%0d] m%0d: got %h want %h", i, m, obs_vec(m), exp_vec(m)); end
         end
         cyc(i < N - 1, 8'h41);
      end
      for (int m = 0; m < 2; m++) begin
         total++;
         if (obs_vec(m) !== exp_vec(m)) begin bad++; $display("FAIL clear_done m%0d: got %h want %h", m, obs_vec(m), exp_vec(m)); end
      end
   endtask

   task automatic test_backspace;
      logic [7:0] seq [4];
      seq = '{8'h08, 8'h61, 8'h62, 8'h08};
      for (int i = 0; i < 4; i++) begin
         cyc(1, seq[i]);
         for (int m = 0; m < 2; m++) begin
            total++;
            if (obs_vec(m) !== exp_vec(m)) begin bad++; $display("FAIL backspace[%0d] m%0d: got %h want %h", i, m, obs_vec(m), exp_vec(m)); end
         end
      end
   endtask

   task automatic test_full;
      do_reset;
      for (int i = 0; i <= N; i++) begin
         cyc(1, rnd_printable());
         for (int m = 0; m < 2; m++) begin
            total++;
            if (obs_vec(m) !== exp_vec(m)) begin bad++; $display("FAIL full[%0d] m%0d: got %h want %h", i, m, obs_vec(m), exp_vec(m)); end
         end
      end
      cyc(1, 8'h08);
      for (int m = 0; m < 2; m++) begin
         total++;
         if (obs_vec(m) !== exp_vec(m)) begin bad++; $display("FAIL full_bs m%0d: got %h want %h", m, obs_vec(m), exp_vec(m)); end
      end
   endtask

   task automatic test_newline;
      do_reset;
      repeat (6) cyc(1, 8'h0A);
      repeat (5) cyc(1, 8'h78);
      for (int i = 0; i < 3; i++) begin
         cyc(i == 0, 8'h0A);
         for (int m = 0; m < 2; m++) begin
            total++;
            if (obs_vec(m) !== exp_vec(m)) begin bad++; $display("FAIL newline[%0d] m%0d: got %h want %h", i, m, obs_vec(m), exp_vec(m)); end
         end
      end
   endtask

   task automatic test_random;
      int r;
      logic [7:0] c;
      do_reset;
      for (int i = 0; i < 900; i++) begin
         r = $urandom_range(0, 199);
         if (r == 0) c = 8'hFF;
         else if (r < 25) c = 8'h08;
         else if (r < 40) c = 8'h0A;
         else if (r < 50) c = 8'($urandom_range(0, 31));
         else c = rnd_printable();
         cyc($urandom_range(0, 4) != 0, c);
         for (int m = 0; m < 2; m++) begin
            total++;
            if (obs_vec(m) !== exp_vec(m)) begin bad++; $display("FAIL random[%0d] m%0d: got %h want %h", i, m, obs_vec(m), exp_vec(m)); end
         end
      end
   endtask

   task automatic test_reset_mid_clear;
      do_reset;
      cyc(1, 8'hFF);
      repeat (50) cyc(0, 8'h00);
      for (int m = 0; m < 2; m++) begin
         total++;
         if (obs_vec(m) !== exp_vec(m) || wr_addr[m] !== AW'(50)) begin
            bad++; $display("FAIL midclear_at50 m%0d: got %h want %h", m, obs_vec(m), exp_vec(m));
         end
      end
      rst_n = 0;
      @(posedge clk); @(negedge clk);
      for (int m = 0; m < 2; m++) begin
         total++;
         if (wr_en[m] !== 1'b0 || busy[m] !== 1'b0 || in_ready[m] !== 1'b0) begin
            bad++; $display("FAIL midclear_abort m%0d: wr_en %b busy %b in_ready %b want 0 0 0", m, wr_en[m], busy[m], in_ready[m]);
         end
      end
      rst_n = 1; #1;
      for (int m = 0; m < 2; m++) begin
         mpos[m] = 0; mfull[m] = 0; e_we[m] = 0; e_sw[m] = 0;
      end
      mbusy = 0; mrdy = 1; clr_idx = 0;
      cyc(0, 8'h00);
      for (int m = 0; m < 2; m++) begin
         total++;
         if (obs_vec(m) !== exp_vec(m)) begin bad++; $display("FAIL midclear_release m%0d: got %h want %h", m, obs_vec(m), exp_vec(m)); end
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset;
      test_basic;
      test_fill;
      test_clear;
      test_backspace;
      test_full;
      test_newline;
      test_random;
      test_reset_mid_clear;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
